// File: rtl/mips32_dmem_responder.sv
// Word-addressed data-memory responder for the MIPS32 MEM stage with programmable access latency.
// Optional per-byte store strobes (req_be) are enabled by defining MIPS32_DMEM_BYTE_STROBE_EN.
module mips32_dmem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef MIPS32_DMEM_BYTE_STROBE_EN
  input  logic [DATA_W/8-1:0] req_be,
`endif
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
`ifdef MIPS32_DMEM_BYTE_STROBE_EN
  logic [BE_W-1:0]   be_q;
`endif
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  logic              acc_c;
  logic              acc_we_c;
  logic [ADDR_W-1:0] acc_addr_c;
  logic [DATA_W-1:0] acc_wdata_c;
  logic [BE_W-1:0]   acc_be_c;
  logic              in_range_c;
  logic              wr_c;
  logic [DATA_W-1:0] rdata_c;

  logic [DATA_W-1:0] mem [DEPTH];

  // Access source: live request for a zero-latency accept, captured request otherwise.
  always_comb begin
    acc_c       = 1'b0;
    acc_we_c    = we_q;
    acc_addr_c  = addr_q;
    acc_wdata_c = wdata_q;
`ifdef MIPS32_DMEM_BYTE_STROBE_EN
    acc_be_c    = be_q;
`else
    acc_be_c    = '1;
`endif
    case (state)
      S_IDLE: begin
        acc_we_c    = req_we;
        acc_addr_c  = req_addr;
        acc_wdata_c = req_wdata;
`ifdef MIPS32_DMEM_BYTE_STROBE_EN
        acc_be_c    = req_be;
`endif
        acc_c       = rst_n && req_valid && (LATENCY == 0);
      end
      S_WAIT:  acc_c = rst_n && (cnt == '0);
      default: acc_c = 1'b0;
    endcase
  end

  assign in_range_c = (32'(acc_addr_c) < 32'(DEPTH));
  assign wr_c       = acc_c && acc_we_c && in_range_c;
  assign rdata_c    = (!acc_we_c && in_range_c) ? mem[acc_addr_c] : '0;

  // Data store, deliberately not reset.
  always_ff @(posedge clk1) begin
    if (wr_c) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (acc_be_c[b]) mem[acc_addr_c][8*b +: 8] <= acc_wdata_c[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef MIPS32_DMEM_BYTE_STROBE_EN
      be_q       <= '0;
`endif
      data_q     <= '0;
      err_q      <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (acc_c) begin
        data_q <= rdata_c;
        err_q  <= !in_range_c;
      end
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
`ifdef MIPS32_DMEM_BYTE_STROBE_EN
            be_q      <= req_be;
`endif
            req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state <= S_RESP;
            end else begin
              cnt   <= CNT_W'(LATENCY - 1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_RESP;
          else           cnt   <= cnt - CNT_W'(1);
        end
        S_RESP: begin
          // Response registers load one edge after the access, then hold until taken.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp_rdata <= data_q;
            resp_err   <= err_q;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
